uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-edge phase alignment,
// break handling and a single-entry valid/ready output register.
module uart_rx #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int OVS_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          rx_m, rx_s;
  logic [CW-1:0] ovs_cnt;
  logic          tick;
  logic [2:0]    state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign tick = (ovs_cnt == CW'(OVS_DIV - 1));

  always_ff @(posedge clock50) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state         <= IDLE;
      ovs_cnt       <= '0;
      tick_cnt      <= 4'd0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      data          <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      ovs_cnt       <= tick ? '0 : ovs_cnt + 1'b1;
      // A load in STOP below overrides this consume-clear on the same edge.
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            ovs_cnt  <= '0;
            tick_cnt <= 4'd0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              if (!rx_s) begin
                bit_idx <= 3'd0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift[bit_idx] <= rx_s;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              if (rx_s) begin
                if (!data_valid || data_ready) begin
                  data       <= shift;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
                state <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state         <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          // Stay here while the line is held low so a break reports once.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: expected bytes are queued as frames are
// driven and compared against bytes the DUT hands over on valid&ready.
module tb_uart_rx;
  localparam int BIT_CLKS = 432;

  logic       clock50 = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid, framing_error, overrun;

  int checks = 0, failures = 0;
  int cyc = 0, t_start = 0, lat_last = -1;
  int dv_rises = 0, dv_run = 0, dv_last_len = 0;
  int fe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
  logic dv_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] e, g;

  uart_rx dut (
    .clock50(clock50), .reset(reset), .rx(rx), .data(data),
    .data_valid(data_valid), .data_ready(data_ready),
    .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clock50 = ~clock50;

  always @(posedge clock50) begin
    cyc++;
    if (data_valid && data_ready) got_q.push_back(data);
  end

  always @(negedge clock50) begin
    if (data_valid && !dv_prev) begin
      dv_rises++;
      lat_last = cyc - t_start;
    end
    if (data_valid) dv_run++;
    else if (dv_run > 0) begin
      dv_last_len = dv_run;
      dv_run = 0;
    end
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((framing_error && fe_prev) || (overrun && ov_prev)) wide_cnt++;
    dv_prev = data_valid;
    fe_prev = framing_error;
    ov_prev = overrun;
  end

  task automatic clear_counts();
    dv_rises = 0; dv_last_len = 0; fe_cnt = 0; ov_cnt = 0; wide_cnt = 0;
    lat_last = -1;
  endtask

  // Leaves rx at the stop-bit level so a 0 stop bit can run into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clock50);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT_CLKS) @(negedge clock50);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clock50);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clock50);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; data_ready = 1'b0;
    repeat (5) @(negedge clock50);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
    checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL rst_fe got=%b exp=0", framing_error); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_ov got=%b exp=0", overrun); end
    reset = 1'b0;
    clear_counts();
    repeat (10000) @(negedge clock50);
    checks++; if (dv_rises != 0) begin failures++; $display("FAIL idle_valid got=%0d exp=0", dv_rises); end
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL idle_fe got=%0d exp=0", fe_cnt); end
    checks++; if (ov_cnt != 0) begin failures++; $display("FAIL idle_ov got=%0d exp=0", ov_cnt); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL idle_data got=%h exp=00", data); end
  endtask

  task automatic test_single();
    data_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'h40);
    send_frame(8'h40, 1'b1);
    repeat (100) @(negedge clock50);
    checks++; if (dv_rises != 1) begin failures++; $display("FAIL single_rises got=%0d exp=1", dv_rises); end
    checks++; if (lat_last < 4100 || lat_last > 4112) begin failures++; $display("FAIL single_latency got=%0d exp=4100..4112", lat_last); end
    checks++; if (dv_last_len != 1) begin failures++; $display("FAIL single_vlen got=%0d exp=1", dv_last_len); end
    checks++; if (data !== 8'h40) begin failures++; $display("FAIL single_data got=%h exp=40", data); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL single_sb got=none exp=%h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL single_sb got=%h exp=%h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL single_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    repeat (50) @(negedge clock50);
    clear_counts();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (50) @(negedge clock50);
    send_frame(8'h3C, 1'b1);
    repeat (50) @(negedge clock50);
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL ovr_data got=%h exp=a5", data); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", data_valid); end
    checks++; if (ov_cnt != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL ovr_fe got=%0d exp=0", fe_cnt); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ovr_early got=%0d exp=0", got_q.size()); end
    data_ready = 1'b1;
    @(negedge clock50);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ovr_consume got=%b exp=0", data_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL ovr_sb got=none exp=%h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL ovr_sb got=%h exp=%h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ovr_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    checks++; if (wide_cnt != 0) begin failures++; $display("FAIL ovr_width got=%0d exp=0", wide_cnt); end
  endtask

  task automatic test_framing();
    data_ready = 1'b1;
    clear_counts();
    send_frame(8'h55, 1'b0);
    repeat (5000) @(negedge clock50);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", fe_cnt); end
    checks++; if (dv_rises != 0) begin failures++; $display("FAIL fe_valid got=%0d exp=0", dv_rises); end
    rx = 1'b1;
    repeat (500) @(negedge clock50);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    repeat (100) @(negedge clock50);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL fe_after got=%0d exp=1", fe_cnt); end
    checks++; if (dv_rises != 1) begin failures++; $display("FAIL fe_recover got=%0d exp=1", dv_rises); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL fe_sb got=none exp=%h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL fe_sb got=%h exp=%h", g, e); end end
    end
    checks++; if (wide_cnt != 0) begin failures++; $display("FAIL fe_width got=%0d exp=0", wide_cnt); end
  endtask

  task automatic test_glitch();
    data_ready = 1'b1;
    clear_counts();
    @(negedge clock50);
    rx = 1'b0;
    repeat (100) @(negedge clock50);
    rx = 1'b1;
    repeat (2000) @(negedge clock50);
    checks++; if (dv_rises != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", dv_rises); end
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (100) @(negedge clock50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL glitch_sb got=none exp=%h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL glitch_sb got=%h exp=%h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    clear_counts();
    @(negedge clock50);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock50);
    rx = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clock50);
    reset = 1'b1;
    @(negedge clock50);
    reset = 1'b0;
    repeat (6 * BIT_CLKS) @(negedge clock50);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (100) @(negedge clock50);
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL rmid_fe got=%0d exp=0", fe_cnt); end
    checks++; if (ov_cnt != 0) begin failures++; $display("FAIL rmid_ov got=%0d exp=0", ov_cnt); end
    checks++; if (dv_rises != 1) begin failures++; $display("FAIL rmid_rises got=%0d exp=1", dv_rises); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL rmid_sb got=none exp=%h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL rmid_sb got=%h exp=%h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rmid_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
